truth_table_lut: RTL and testbench



---
 rtl/truth_table_lut.sv | 110 +++++++++++
 tb/tb_truth_table_lut.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_lut.sv
// Runtime-programmable N-input truth-table evaluator: valid/ready evaluation
// stream plus a serial, MSB-first table load port with abort and versioning.
module truth_table_lut #(
   parameter int unsigned N_IN = 3,
   localparam int unsigned TT_BITS = 2**N_IN,
   parameter logic [TT_BITS-1:0] INIT_TABLE = TT_BITS'(8'hE2)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [N_IN-1:0] in_vec,
   output logic            out_valid,
   input  logic            out_ready,
   output logic            out_bit,
   input  logic            cfg_valid,
   output logic            cfg_ready,
   input  logic            cfg_bit,
   input  logic            cfg_abort,
   output logic            cfg_busy,
   output logic [7:0]      tbl_version
);

   localparam int unsigned CW = $clog2(TT_BITS) + 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      COMMIT = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [TT_BITS-1:0]  shadow_q, shadow_d;
   logic [TT_BITS-1:0]  table_q, table_d;
   logic [7:0]          ver_d;

   // Evaluation never waits on the config port.
   assign in_ready  = !out_valid || out_ready;
   assign cfg_ready = (state_q != COMMIT);
   assign cfg_busy  = (state_q != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         shadow_q    <= '0;
         table_q     <= INIT_TABLE;
         tbl_version <= 8'd0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         shadow_q    <= shadow_d;
         table_q     <= table_d;
         tbl_version <= ver_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      shadow_d = shadow_q;
      table_d  = table_q;
      ver_d    = tbl_version;
      case (state_q)
         IDLE: begin
            if (cfg_valid) begin
               shadow_d = {shadow_q[TT_BITS-2:0], cfg_bit};
               cnt_d    = CW'(1);
               state_d  = SHIFT;
            end
         end
         SHIFT: begin
            // Abort wins over a bit presented in the same cycle.
            if (cfg_abort) begin
               cnt_d   = '0;
               state_d = IDLE;
            end else if (cfg_valid) begin
               shadow_d = {shadow_q[TT_BITS-2:0], cfg_bit};
               if (cnt_q == CW'(TT_BITS - 1)) begin
                  cnt_d   = '0;
                  state_d = COMMIT;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         COMMIT: begin
            table_d = shadow_q;
            ver_d   = tbl_version + 8'd1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Row 0 sits at the MSB, so the bit index is the inverted input vector.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_bit   <= 1'b0;
      end else if (in_valid && in_ready) begin
         out_valid <= 1'b1;
         out_bit   <= table_q[~in_vec];
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_truth_table_lut.sv
// Self-checking bench for truth_table_lut (N_IN=3): directed vector tables,
// multi-cycle corner sequences and a cycle-level reference model.
module tb_truth_table_lut;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [2:0] in_vec = 3'd0;
   logic       out_valid;
   logic       out_ready = 1'b1;
   logic       out_bit;
   logic       cfg_valid = 1'b0;
   logic       cfg_ready;
   logic       cfg_bit = 1'b0;
   logic       cfg_abort = 1'b0;
   logic       cfg_busy;
   logic [7:0] tbl_version;

   int n_checks = 0;
   int n_fail = 0;

   truth_table_lut #(.N_IN(3), .INIT_TABLE(8'hE2)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
      .out_valid(out_valid), .out_ready(out_ready), .out_bit(out_bit),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_bit(cfg_bit),
      .cfg_abort(cfg_abort), .cfg_busy(cfg_busy), .tbl_version(tbl_version)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: row i of a table is bit (7-i), row 0 being the MSB.
   function automatic logic ref_eval(input int tbl, input int row);
      return 1'((tbl >> (7 - row)) & 1);
   endfunction

   // ---------------- cycle-level reference model ----------------
   int  m_table = 'hE2;
   int  m_version = 0;
   int  m_cnt = 0;
   int  m_acc = 0;
   bit  m_commit = 0;
   bit  m_ov = 0;
   bit  m_ob = 0;

   always @(negedge clk) begin
      logic [12:0] act, exp;
      bit m_in_ready;
      if (!rst_n) begin
         m_table = 'hE2; m_version = 0; m_cnt = 0; m_acc = 0;
         m_commit = 0; m_ov = 0; m_ob = 0;
      end
      m_in_ready = !m_ov || out_ready;
      act = {out_valid, out_bit, in_ready, cfg_ready, cfg_busy, tbl_version};
      exp = {m_ov, m_ob, m_in_ready, !m_commit, (m_cnt != 0) || m_commit, 8'(m_version)};
      chk("model", 32'(act), 32'(exp));
      if (rst_n) begin
         if (in_valid && m_in_ready) begin
            m_ob = ref_eval(m_table, int'(in_vec));
            m_ov = 1;
         end else if (out_ready) begin
            m_ov = 0;
         end
         if (m_commit) begin
            m_table = m_acc;
            m_version = (m_version + 1) % 256;
            m_commit = 0;
         end else if (cfg_abort && m_cnt != 0) begin
            m_cnt = 0;
            m_acc = 0;
         end else if (cfg_valid) begin
            m_acc = ((m_acc << 1) | int'(cfg_bit)) & 'hFF;
            m_cnt++;
            if (m_cnt == 8) begin
               m_cnt = 0;
               m_commit = 1;
            end
         end
      end
   end

   // Full back-to-back load with per-cycle busy/ready checks.
   task automatic load_tbl(input logic [7:0] v);
      int lows = 0;
      for (int b = 7; b >= 0; b--) begin
         cfg_valid = 1'b1;
         cfg_bit   = v[b];
         tick();
         chk("load_busy", 32'(cfg_busy), 32'd1);
         chk("load_ready", 32'(cfg_ready), (b != 0) ? 32'd1 : 32'd0);
         if (!cfg_ready) lows++;
      end
      cfg_valid = 1'b0;
      tick();
      chk("load_done_busy", 32'(cfg_busy), 32'd0);
      chk("load_ready_lows", 32'(lows), 32'd1);
   endtask

   typedef struct {
      logic [2:0] vec;
      logic       exp;
   } vec_t;

   vec_t init_v[8];
   vec_t t96_v[8];

   initial begin
      logic [7:0] last_v;
      logic [7:0] rv;
      init_v = '{'{3'd0,1'b1}, '{3'd1,1'b1}, '{3'd2,1'b1}, '{3'd3,1'b0},
                 '{3'd4,1'b0}, '{3'd5,1'b0}, '{3'd6,1'b1}, '{3'd7,1'b0}};
      t96_v  = '{'{3'd0,1'b1}, '{3'd1,1'b0}, '{3'd2,1'b0}, '{3'd3,1'b1},
                 '{3'd4,1'b0}, '{3'd5,1'b1}, '{3'd6,1'b1}, '{3'd7,1'b0}};

      rst_n = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      tick();
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_bit", 32'(out_bit), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);
      chk("rst_cfg_busy", 32'(cfg_busy), 32'd0);
      chk("rst_version", 32'(tbl_version), 32'd0);

      // Default table, one result per cycle.
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1;
         in_vec   = init_v[i].vec;
         tick();
         chk("init_valid", 32'(out_valid), 32'd1);
         chk("init_bit", 32'(out_bit), 32'(init_v[i].exp));
      end
      in_valid = 1'b0;
      tick();
      chk("init_drain", 32'(out_valid), 32'd0);

      // Abort after 5 bits of zeros, with a bit presented alongside the abort.
      for (int i = 0; i < 5; i++) begin
         cfg_valid = 1'b1; cfg_bit = 1'b0;
         tick();
      end
      chk("abort_busy_pre", 32'(cfg_busy), 32'd1);
      cfg_abort = 1'b1;
      tick();
      cfg_abort = 1'b0; cfg_valid = 1'b0;
      chk("abort_idle", 32'(cfg_busy), 32'd0);
      in_valid = 1'b1; in_vec = 3'd6;
      tick();
      in_valid = 1'b0;
      chk("abort_table", 32'(out_bit), 32'd1);
      chk("abort_version", 32'(tbl_version), 32'd0);
      tick();

      // Backpressure: result held, next input waits, then drains in order.
      out_ready = 1'b0;
      in_valid = 1'b1; in_vec = 3'd0;
      tick();
      in_vec = 3'd3;
      for (int i = 0; i < 10; i++) begin
         chk("bp_in_ready", 32'(in_ready), 32'd0);
         chk("bp_hold", 32'({out_valid, out_bit}), 32'b11);
         tick();
      end
      out_ready = 1'b1;
      #1;
      chk("bp_release_ready", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      chk("bp_next", 32'({out_valid, out_bit}), 32'b10);
      tick();
      chk("bp_no_dup", 32'(out_valid), 32'd0);

      // Commit collision: evaluation held on row 3 across a load of all-ones.
      in_valid = 1'b1; in_vec = 3'd3;
      load_tbl(8'hFF);
      chk("coll_commit_cycle", 32'(out_bit), 32'd0);
      tick();
      chk("coll_next", 32'(out_bit), 32'd1);
      in_valid = 1'b0;
      tick();

      // Serial load of 8'h96 then the full vector table.
      load_tbl(8'h96);
      chk("load96_version", 32'(tbl_version), 32'd2);
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1;
         in_vec   = t96_v[i].vec;
         tick();
         chk("t96_bit", 32'(out_bit), 32'(t96_v[i].exp));
      end
      in_valid = 1'b0;
      tick();

      // Reset mid-load with a result pending.
      out_ready = 1'b0;
      in_valid = 1'b1; in_vec = 3'd0;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         cfg_valid = 1'b1; cfg_bit = 1'b1;
         tick();
      end
      #2;
      rst_n = 1'b0;
      #1;
      chk("mrst_out", 32'({out_valid, out_bit}), 32'b00);
      chk("mrst_cfg", 32'({in_ready, cfg_ready, cfg_busy}), 32'b110);
      chk("mrst_version", 32'(tbl_version), 32'd0);
      tick(); tick();
      rst_n = 1'b1; cfg_valid = 1'b0; out_ready = 1'b1;
      tick();
      in_valid = 1'b1; in_vec = 3'd3;
      tick();
      chk("mrst_table_r3", 32'(out_bit), 32'd0);
      in_vec = 3'd6;
      tick();
      chk("mrst_table_r6", 32'(out_bit), 32'd1);
      in_valid = 1'b0;
      tick();

      // 256 loads: version wraps on the last commit.
      last_v = 8'h00;
      for (int k = 1; k <= 256; k++) begin
         rv = 8'($urandom_range(0, 255));
         last_v = rv;
         load_tbl(rv);
         if (k == 255) chk("ver_255", 32'(tbl_version), 32'd255);
      end
      chk("ver_wrap", 32'(tbl_version), 32'd0);
      in_valid = 1'b1; in_vec = 3'd5;
      tick();
      in_valid = 1'b0;
      chk("wrap_table", 32'(out_bit), 32'(ref_eval(int'(last_v), 5)));
      tick();

      // Randomised traffic on both ports, checked by the model.
      for (int i = 0; i < 3000; i++) begin
         in_valid  = 1'($urandom_range(0, 1));
         in_vec    = 3'($urandom_range(0, 7));
         out_ready = ($urandom_range(0, 3) != 0);
         cfg_valid = 1'($urandom_range(0, 1));
         cfg_bit   = 1'($urandom_range(0, 1));
         cfg_abort = ($urandom_range(0, 19) == 0);
         tick();
      end
      in_valid = 1'b0; cfg_valid = 1'b0; cfg_abort = 1'b0; out_ready = 1'b1;
      repeat (12) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
